// File: rtl/mem_if_pkg.sv
// Shared widths, read-latency default and sequencer state encoding for the
// 256x64 RAM burst master.
package mem_if_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 64;
  localparam int LEN_W_DEF  = 4;
  localparam int RD_LAT_DEF = 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_BEAT,
    RD_ISSUE,
    RD_DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/rd_valid_pipe.sv
// RD_LAT-deep shift register tracking which issued read addresses are still
// waiting for their RAM data.
module rd_valid_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  output logic out_o,
  output logic empty_o
);

  logic [RD_LAT-1:0] stage_q;
  logic [RD_LAT-1:0] stage_d;
  logic              behind;

  always_comb begin
    stage_d    = '0;
    stage_d[0] = push_i;
    for (int i = 1; i < RD_LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // empty_o means nothing is queued behind the output stage, so the pipe is
  // drained once the bit currently at the output has been consumed.
  always_comb begin
    behind = 1'b0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      behind = behind | stage_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_o   = stage_q[RD_LAT-1];
  assign empty_o = !behind;

endmodule

// File: rtl/ram_burst_master.sv
// Burst sequencer that owns the RAM port: steps addresses per beat for write
// bursts (valid/ready data in) and read bursts (valid-strobed data out).
module ram_burst_master
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_data_valid,
  output logic              wr_data_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_wrt,
  input  logic [DATA_W-1:0] ram_data_out
);

  state_e            state_q;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [LEN_W-1:0]  remaining_q;

  logic beat_fire;
  logic issue;
  logic drive_addr;
  logic pipe_out;
  logic pipe_empty;

  assign beat_fire  = (state_q == WR_BEAT) && wr_data_valid;
  assign issue      = (state_q == RD_ISSUE);
  assign drive_addr = (beat_fire || issue) && !rst;

  // The RAM port is driven combinationally in the beat cycle; otherwise the
  // address holds whatever was last presented.
  assign ram_addr    = drive_addr ? cur_addr_q : ram_addr_q;
  assign ram_wrt     = beat_fire && !rst;
  assign ram_data_in = (beat_fire && !rst) ? wr_data : '0;

  assign req_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign wr_data_ready = (state_q == WR_BEAT);
  assign rd_valid      = pipe_out;
  assign rd_data       = ram_data_out;

  rd_valid_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_valid_pipe (
    .clk     (clk),
    .rst     (rst),
    .push_i  (issue),
    .out_o   (pipe_out),
    .empty_o (pipe_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      ram_addr_q  <= '0;
    end else begin
      ram_addr_q <= ram_addr;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            cur_addr_q  <= req_addr;
            remaining_q <= req_len;
            state_q     <= req_write ? WR_BEAT : RD_ISSUE;
          end
        end
        WR_BEAT: begin
          if (wr_data_valid) begin
            cur_addr_q  <= cur_addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - LEN_W'(1);
            if (remaining_q == '0) begin
              state_q <= DONE;
            end
          end
        end
        RD_ISSUE: begin
          cur_addr_q  <= cur_addr_q + ADDR_W'(1);
          remaining_q <= remaining_q - LEN_W'(1);
          if (remaining_q == '0) begin
            state_q <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (pipe_empty) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Scoreboard bench: two masters (RD_LAT=1 and RD_LAT=3), each with its own
// behavioural RAM; expected writes and read data are queued at stimulus time.
module tb_ram_burst_master;

  logic        clk;
  logic        rst;
  logic        ram_init;

  logic        req_valid     [2];
  logic        req_ready     [2];
  logic        req_write     [2];
  logic [7:0]  req_addr      [2];
  logic [3:0]  req_len       [2];
  logic [63:0] wr_data       [2];
  logic        wr_data_valid [2];
  logic        wr_data_ready [2];
  logic [63:0] rd_data       [2];
  logic        rd_valid      [2];
  logic        busy          [2];
  logic        done          [2];
  logic [7:0]  ram_addr      [2];
  logic [63:0] ram_data_in   [2];
  logic        ram_wrt       [2];
  logic [63:0] ram_data_out  [2];

  logic [63:0] mem    [2][256];
  logic [63:0] shadow [2][256];
  logic [63:0] p0, p1a, p1b, p1c;

  typedef struct {
    int          s;
    logic [7:0]  a;
    logic [63:0] d;
  } wr_t;

  typedef struct {
    int          s;
    logic [63:0] d;
  } rd_t;

  wr_t wq[$];
  rd_t rq[$];

  int n_chk  = 0;
  int n_fail = 0;

  ram_burst_master #(.RD_LAT(1)) dut0 (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid[0]),
    .req_ready     (req_ready[0]),
    .req_write     (req_write[0]),
    .req_addr      (req_addr[0]),
    .req_len       (req_len[0]),
    .wr_data       (wr_data[0]),
    .wr_data_valid (wr_data_valid[0]),
    .wr_data_ready (wr_data_ready[0]),
    .rd_data       (rd_data[0]),
    .rd_valid      (rd_valid[0]),
    .busy          (busy[0]),
    .done          (done[0]),
    .ram_addr      (ram_addr[0]),
    .ram_data_in   (ram_data_in[0]),
    .ram_wrt       (ram_wrt[0]),
    .ram_data_out  (ram_data_out[0])
  );

  ram_burst_master #(.RD_LAT(3)) dut1 (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid[1]),
    .req_ready     (req_ready[1]),
    .req_write     (req_write[1]),
    .req_addr      (req_addr[1]),
    .req_len       (req_len[1]),
    .wr_data       (wr_data[1]),
    .wr_data_valid (wr_data_valid[1]),
    .wr_data_ready (wr_data_ready[1]),
    .rd_data       (rd_data[1]),
    .rd_valid      (rd_valid[1]),
    .busy          (busy[1]),
    .done          (done[1]),
    .ram_addr      (ram_addr[1]),
    .ram_data_in   (ram_data_in[1]),
    .ram_wrt       (ram_wrt[1]),
    .ram_data_out  (ram_data_out[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  // Behavioural RAMs: read latency 1 for dut0, 3 for dut1.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) begin
        mem[0][i] <= init_word(i);
        mem[1][i] <= init_word(i);
      end
    end else begin
      if (ram_wrt[0]) mem[0][ram_addr[0]] <= ram_data_in[0];
      if (ram_wrt[1]) mem[1][ram_addr[1]] <= ram_data_in[1];
    end
    p0  <= mem[0][ram_addr[0]];
    p1a <= mem[1][ram_addr[1]];
    p1b <= p1a;
    p1c <= p1b;
  end

  assign ram_data_out[0] = p0;
  assign ram_data_out[1] = p1c;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (ram_wrt[s] === 1'b1) begin
        wr_t e;
        e = '{s: -1, a: 8'h00, d: 64'h0};
        if (wq.size() > 0) e = wq.pop_front();
        chk("wr_dut", 64'(s), 64'(e.s));
        chk("wr_addr", 64'(ram_addr[s]), 64'(e.a));
        chk("wr_data", ram_data_in[s], e.d);
      end
      if (rd_valid[s] === 1'b1) begin
        rd_t r;
        r = '{s: -1, d: 64'h0};
        if (rq.size() > 0) r = rq.pop_front();
        chk("rd_dut", 64'(s), 64'(r.s));
        chk("rd_data", rd_data[s], r.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  task automatic request(input int s, input logic w, input logic [7:0] a,
                         input int len, output int waits);
    @(posedge clk);
    #1;
    req_valid[s]     = 1'b1;
    req_write[s]     = w;
    req_addr[s]      = a;
    req_len[s]       = 4'(len);
    wr_data_valid[s] = 1'b0;
    waits = 0;
    @(negedge clk);
    while (!req_ready[s] && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    chk("req_ready", 64'(req_ready[s]), 64'd1);
    @(posedge clk);
  endtask

  task automatic do_write(input int s, input logic [7:0] a, input int len,
                          input logic [63:0] base, input logic [31:0] vpat,
                          input int exp_done, input logic hold, input logic [7:0] hold_a);
    int         w;
    int         beat;
    logic [7:0] ba;
    beat = 0;
    request(s, 1'b1, a, len, w);
    for (int k = 1; k <= exp_done; k++) begin
      #1;
      req_valid[s] = hold;
      if (hold) begin
        req_write[s] = 1'b0;
        req_addr[s]  = hold_a;
        req_len[s]   = 4'd0;
      end
      wr_data_valid[s] = vpat[k-1];
      wr_data[s]       = base + 64'(beat);
      if (vpat[k-1] && beat <= len) begin
        ba = a + 8'(beat);
        wq.push_back('{s: s, a: ba, d: base + 64'(beat)});
        shadow[s][ba] = base + 64'(beat);
        beat++;
      end
      @(negedge clk);
      chk("wr_done", 64'(done[s]), 64'(k == exp_done));
      chk("wr_busy", 64'(busy[s]), 64'd1);
      chk("wr_ready", 64'(wr_data_ready[s]), 64'(k < exp_done));
      chk("req_ready_busy", 64'(req_ready[s]), 64'd0);
      if (k < exp_done) @(posedge clk);
    end
    chk("wq_empty", 64'(wq.size()), 64'd0);
  endtask

  task automatic do_read(input int s, input logic [7:0] a, input int len,
                         input int lat, input int exp_wait);
    int         w;
    int         n;
    int         exp_done;
    logic [7:0] ea;
    n        = len + 1;
    exp_done = n + lat + 1;
    for (int i = 0; i < n; i++) begin
      ea = a + 8'(i);
      rq.push_back('{s: s, d: shadow[s][ea]});
    end
    request(s, 1'b0, a, len, w);
    if (exp_wait >= 0) chk("req_wait", 64'(w), 64'(exp_wait));
    for (int k = 1; k <= exp_done; k++) begin
      #1;
      req_valid[s] = 1'b0;
      @(negedge clk);
      ea = (k <= n) ? a + 8'(k - 1) : a + 8'(len);
      chk("rd_addr", 64'(ram_addr[s]), 64'(ea));
      chk("rd_valid", 64'(rd_valid[s]), 64'(k > lat && k <= n + lat));
      chk("rd_done", 64'(done[s]), 64'(k == exp_done));
      chk("rd_busy", 64'(busy[s]), 64'd1);
      chk("rd_wrt", 64'(ram_wrt[s]), 64'd0);
      if (k < exp_done) @(posedge clk);
    end
    chk("rq_empty", 64'(rq.size()), 64'd0);
  endtask

  initial begin
    int         w;
    logic [7:0] hold_none;
    hold_none = 8'h00;
    for (int s = 0; s < 2; s++) begin
      req_valid[s]     = 1'b0;
      req_write[s]     = 1'b0;
      req_addr[s]      = 8'h00;
      req_len[s]       = 4'd0;
      wr_data[s]       = 64'h0;
      wr_data_valid[s] = 1'b0;
      for (int i = 0; i < 256; i++) shadow[s][i] = init_word(i);
    end
    rst      = 1'b1;
    ram_init = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_wr_ready", 64'(wr_data_ready[s]), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid[s]), 64'd0);
      chk("rst_busy", 64'(busy[s]), 64'd0);
      chk("rst_done", 64'(done[s]), 64'd0);
      chk("rst_ram_addr", 64'(ram_addr[s]), 64'd0);
      chk("rst_ram_din", ram_data_in[s], 64'd0);
      chk("rst_ram_wrt", 64'(ram_wrt[s]), 64'd0);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    ram_init = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) chk("post_rst_ready", 64'(req_ready[s]), 64'd1);

    // Wrapping write then read-back across 0xFF -> 0x00.
    do_write(0, 8'hFE, 3, 64'h1, 32'hFFFF_FFFF, 5, 1'b0, hold_none);
    do_read(0, 8'hFE, 3, 1, -1);

    // Stalled write: valid 1,0,0,1,1.
    do_write(0, 8'h30, 2, 64'h3000, 32'b11001, 6, 1'b0, hold_none);
    do_read(0, 8'h30, 2, 1, -1);

    // Request held during a burst is only taken after done.
    do_write(0, 8'h20, 1, 64'hAA00, 32'hFFFF_FFFF, 3, 1'b1, 8'h55);
    do_read(0, 8'h55, 0, 1, 0);

    // Reset in the second beat of a four-beat write.
    request(0, 1'b1, 8'h40, 3, w);
    #1;
    req_valid[0]     = 1'b0;
    wr_data_valid[0] = 1'b1;
    wr_data[0]       = 64'h4000;
    wq.push_back('{s: 0, a: 8'h40, d: 64'h4000});
    shadow[0][8'h40] = 64'h4000;
    @(negedge clk);
    chk("abort_beat1_wrt", 64'(ram_wrt[0]), 64'd1);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    wr_data[0] = 64'h4001;
    @(negedge clk);
    chk("abort_rst_wrt", 64'(ram_wrt[0]), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_busy", 64'(busy[0]), 64'd0);
      chk("abort_done", 64'(done[0]), 64'd0);
      chk("abort_ready", 64'(req_ready[0]), 64'd1);
      chk("abort_rd_valid", 64'(rd_valid[0]), 64'd0);
      chk("abort_wrt", 64'(ram_wrt[0]), 64'd0);
      @(posedge clk);
    end
    #1;
    wr_data_valid[0] = 1'b0;
    chk("abort_wq_empty", 64'(wq.size()), 64'd0);
    do_read(0, 8'h40, 3, 1, -1);

    // Single-beat read with three-cycle RAM latency.
    do_read(1, 8'h10, 0, 3, -1);
    do_write(1, 8'h11, 0, 64'hBEEF, 32'hFFFF_FFFF, 2, 1'b0, hold_none);
    do_read(1, 8'h10, 1, 3, -1);

    @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) chk("final_idle", 64'(busy[s]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_burst_master.md
Name: ram_burst_master

Overview:
- Initiator-side sequencer that drives the 256x64 RAM's port (addr, data_in, wrt, data_out) on behalf of a client.
- Accepts one burst request at a time (read or write, 1–16 beats, starting address) and steps the RAM address per beat.
- Streams write data in with a valid/ready handshake and streams read data out with a valid strobe.
- Sits between the datapath/DMA client and the RAM; it is the only agent driving the RAM port.

Parameters:
- ADDR_W, 8: RAM address width (256 words).
- DATA_W, 64: RAM word width.
- LEN_W, 4: burst length field width; beats = req_len+1.
- RD_LAT, 1: cycles from address presented to valid ram_data_out. Legal values: 1..3.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  burst request present.
- req_ready  out  1  high only in IDLE; request accepted when req_valid&&req_ready.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_W  start address.
- req_len  in  LEN_W  beats minus one.
- wr_data  in  DATA_W  write beat data.
- wr_data_valid  in  1  write beat offered.
- wr_data_ready  out  1  block accepts write beat.
- rd_data  out  DATA_W  read beat data, pass-through of ram_data_out.
- rd_valid  out  1  rd_data valid this cycle. No backpressure.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a burst completes.
- ram_addr  out  ADDR_W  RAM address.
- ram_data_in  out  DATA_W  RAM write data.
- ram_wrt  out  1  RAM write enable.
- ram_data_out  in  DATA_W  RAM read data.

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous and active-high. On reset:
  - state = IDLE, address and beat counters = 0, read-valid pipe cleared.
  - Outputs: req_ready=1 (after reset release), wr_data_ready=0, rd_valid=0, busy=0, done=0, ram_addr=0, ram_data_in=0, ram_wrt=0.
- States: IDLE, WR_BEAT, RD_ISSUE, RD_DRAIN, DONE.
- IDLE:
  - On accept, latch cur_addr=req_addr and remaining=req_len.
  - Go to WR_BEAT if req_write, else RD_ISSUE.
- WR_BEAT:
  - wr_data_ready=1.
  - When wr_data_valid: ram_wrt=1, ram_addr=cur_addr, ram_data_in=wr_data (all combinational in that cycle); cur_addr+=1; remaining-=1.
  - The beat with remaining==0 goes to DONE.
  - Stalls (wr_data_valid=0) hold state with ram_wrt=0.
- RD_ISSUE:
  - Presents ram_addr=cur_addr every cycle; cur_addr+=1; a 1 is pushed into the RD_LAT-deep valid pipe.
  - After the remaining==0 issue, go to RD_DRAIN.
- Read data timing:
  - rd_valid = pipe output, asserted RD_LAT cycles after the matching address.
  - rd_data = ram_data_out whenever rd_valid=1; don't-care otherwise.
- RD_DRAIN: zeros shift into the pipe; go to DONE once the pipe is empty (last rd_valid seen).
- DONE: done=1 for one cycle, busy=1, then IDLE. req_ready is 0 here, so a new request costs at least one idle cycle.
- Latency:
  - Write of N beats with continuous valid: accept at cycle 0, writes at cycles 1..N, done at N+1.
  - Read of N beats: addresses at cycles 1..N, rd_valid at 1+RD_LAT..N+RD_LAT, done at N+RD_LAT+1.
- Address arithmetic: cur_addr wraps modulo 2^ADDR_W (255 -> 0) with no error.
- ram_addr in IDLE/DONE/RD_DRAIN holds its last driven value. ram_wrt is 0 in every state except a WR_BEAT cycle with a valid beat.
- Write-enable gating: ram_wrt is gated with !rst, so no RAM write occurs in any cycle where rst=1.
- Reset mid-burst: aborts the burst, with no done pulse and no further rd_valid after the reset edge. RAM words already written stay written.
- Ignored inputs: req_valid while busy is ignored; wr_data_valid outside WR_BEAT is ignored (wr_data_ready=0).

Decomposition:
- Package mem_if_pkg:
  - ADDR_W/DATA_W/LEN_W defaults.
  - State enum {IDLE, WR_BEAT, RD_ISSUE, RD_DRAIN, DONE}.
  - RD_LAT default.
- Sub-module rd_valid_pipe:
  - RD_LAT-deep shift register of valid bits.
  - Synchronous reset clears all stages.
  - Exposes the output bit and an "empty" flag.

Test Plan:
1. Write burst, addr=8'hFE, len=3, data 64'h1..64'h4, continuous valid -> ram_wrt high at cycles 1–4 with ram_addr FE,FF,00,01; done at cycle 5; RAM[FE..01] read back as 1..4.
2. Read burst, addr=8'hFE, len=3, RD_LAT=1 -> ram_addr FE,FF,00,01 at cycles 1–4; rd_valid at cycles 2–5 with rd_data 1,2,3,4; done at cycle 6.
3. Write burst, len=2, wr_data_valid toggling 1,0,0,1,1 -> exactly 3 ram_wrt pulses at consecutive addresses; no write in stall cycles; done one cycle after the third beat.
4. req_valid held high during a burst with a different addr -> ignored; second request accepted only in the cycle after the done pulse, when req_ready=1.
5. rst asserted in the 2nd beat of a 4-beat write -> ram_wrt=0 that cycle; IDLE, busy=0, no done pulse; the 3rd and 4th addresses are unchanged in RAM.
6. Single-beat read (len=0) with RD_LAT=3 -> one rd_valid at cycle 4; done at cycle 5; busy high at cycles 1–5.
